writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS core: holds the MEM/WB latch and selects the write-back value (ALU result, sign/zero-extended load data, or link address).
- Drives the register-bank write port consumed by instruction decode: write enable, write address, write data.
- Tracks halt and counts retired instructions for the debug unit.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- REG_ADDR_WIDTH, 5, register index width.
- LINK_OFFSET, 8, value added to the jump PC for the link write.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  MEM stage presents an instruction this cycle.
- i_reg_write  in  1  instruction writes a register.
- i_mem_to_reg  in  1  write value comes from memory.
- i_link  in  1  write value is i_pc+LINK_OFFSET (JAL/JALR).
- i_halt  in  1  instruction is HALT.
- i_opcode  in  6  opcode, selects load width and sign.
- i_byte_offset  in  2  low address bits of the load.
- i_alu_result  in  DATA_WIDTH  EX result.
- i_mem_data  in  DATA_WIDTH  raw aligned memory word.
- i_pc  in  DATA_WIDTH  address of the instruction.
- i_dest  in  REG_ADDR_WIDTH  destination register.
- o_wb_write_enable  out  1  register-bank write enable.
- o_wb_write_addr  out  REG_ADDR_WIDTH  register-bank write address.
- o_wb_write_data  out  DATA_WIDTH  register-bank write data.
- o_halted  out  1  HALT has retired; sticky.
- o_retired_count  out  32  number of retired valid instructions.

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0; state RUN. Reset mid-operation drops the latched instruction with no write.
- Latency is 1 cycle. Data selection and extension are combinational before the latch. Values captured at edge N appear on the outputs throughout cycle N+1.
- Select priority: i_link, then i_mem_to_reg, then i_alu_result. Link data = i_pc + LINK_OFFSET, modulo 2^32.
- Load extension for little-endian byte lanes (byte k = bits [8k+7:8k]):
  - LB 100000: sign-extend byte i_byte_offset.
  - LBU 100100: zero-extend byte i_byte_offset.
  - LH 100001: sign-extend halfword i_byte_offset[1] (bit 0 ignored).
  - LHU 100101: zero-extend halfword i_byte_offset[1].
  - LW 100011 and any other opcode: full word.
- o_wb_write_enable = i_valid & i_reg_write & (i_dest != 0) & ~i_halt, captured only in RUN. Register $0 is never written. Addr and data are latched whenever a valid instruction is captured, including when enable=0.
- Invalid input cycle (i_valid=0): enable latches 0; addr, data and count unchanged.
- States:
  - RUN: normal capture. A captured valid instruction with i_halt=1 sets HALTED at that edge. o_halted=1 from cycle N+1; the HALT itself never writes.
  - HALTED: all inputs ignored; enable held 0; count frozen. Only reset exits.
- o_retired_count increments by 1 per valid instruction captured in RUN, HALT included. It wraps 0xFFFFFFFF to 0.
- No stall input: WB never stalls. Upstream presents a bubble via i_valid=0.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants: OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU.
  - WB state typedef: WB_RUN, WB_HALTED.
  - LINK_OFFSET default.
- Sub-module load_extender: combinational; takes opcode, byte offset and raw word, returns the extended word. Reusable by the memory-stage forwarding path.

Test Plan:
- ALU write: valid, reg_write=1, dest=5, alu=0x12345678 → next cycle enable=1, addr=5, data=0x12345678, count=1.
- Loads, mem_data=0x80FF7F01:
  - LB offset 3 → 0xFFFFFF80.
  - LBU offset 3 → 0x00000080.
  - LH offset 2 → 0xFFFF80FF.
  - LHU offset 1 → 0x00007F01.
  - LW → 0x80FF7F01.
- Link priority: link=1, mem_to_reg=1, pc=0x00000040, dest=31 → data=0x00000048, addr=31, enable=1.
- $0 guard and bubble: reg_write=1, dest=0 → enable=0, count increments; i_valid=0 → enable=0, count unchanged.
- Halt: HALT with reg_write=1, dest=3, then an ALU write to dest=4 → enable stays 0 both cycles, o_halted=1 from the cycle after HALT capture, count stops at HALT. Pulse i_reset low → o_halted=0, count=0 immediately.
- Wrap: preload 0xFFFFFFFF retirements (or force), one more valid → count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the MIPS core back end: load opcodes,
//               write-back state encoding and the default link offset.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Load opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  // Write-back stage run state
  typedef enum logic [0:0] {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

  // JAL/JALR write the address two instructions past the jump
  localparam int LINK_OFFSET_DEFAULT = 8;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Combinational byte/halfword lane select with sign or zero
//               extension for little-endian loads. Reusable by any stage that
//               needs the architectural load value from a raw aligned word.
// Ports       : i_opcode      - load opcode, selects width and signedness
//               i_byte_offset - low address bits of the load
//               i_raw         - raw aligned memory word
//               o_ext         - extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_extender
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [5:0]            i_opcode,
  input  logic [1:0]            i_byte_offset,
  input  logic [DATA_WIDTH-1:0] i_raw,
  output logic [DATA_WIDTH-1:0] o_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = i_raw[{3'd0, i_byte_offset} * 8 +: 8];
    // Halfword lane comes from offset bit 1 only; bit 0 is ignored
    half_sel = i_byte_offset[1] ? i_raw[31:16] : i_raw[15:0];

    case (i_opcode)
      OP_LB:   o_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  o_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      OP_LH:   o_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      OP_LHU:  o_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: o_ext = i_raw;
    endcase
  end

endmodule : load_extender
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB latch and write-back value selection for the MIPS core.
//               Drives the register-bank write port, tracks HALT and counts
//               retired instructions.
// Ports       : i_clk, i_reset (async, active low)
//               i_valid, i_reg_write, i_mem_to_reg, i_link, i_halt - controls
//               i_opcode, i_byte_offset - load width/sign and lane
//               i_alu_result, i_mem_data, i_pc, i_dest - datapath inputs
//               o_wb_write_enable/addr/data - register-bank write port
//               o_halted - sticky HALT-retired flag
//               o_retired_count - retired valid instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_OFFSET    = LINK_OFFSET_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_link,
  input  logic                      i_halt,
  input  logic [5:0]                i_opcode,
  input  logic [1:0]                i_byte_offset,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_pc,
  input  logic [REG_ADDR_WIDTH-1:0] i_dest,
  output logic                      o_wb_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_write_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_write_data,
  output logic                      o_halted,
  output logic [31:0]               o_retired_count
);

  wb_state_e                 state_q;
  logic                      we_q;
  logic                      we_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [DATA_WIDTH-1:0]     data_d;
  logic [DATA_WIDTH-1:0]     load_ext;
  logic                      halted_q;
  logic [31:0]               count_q;

  load_extender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extender (
    .i_opcode      (i_opcode),
    .i_byte_offset (i_byte_offset),
    .i_raw         (i_mem_data),
    .o_ext         (load_ext)
  );

  always_comb begin
    // Link beats memory, memory beats ALU
    if (i_link) begin
      data_d = i_pc + DATA_WIDTH'(LINK_OFFSET);
    end else if (i_mem_to_reg) begin
      data_d = load_ext;
    end else begin
      data_d = i_alu_result;
    end
    // $0 is hardwired zero and HALT never writes
    we_d = i_valid & i_reg_write & (i_dest != '0) & ~i_halt;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= WB_RUN;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        WB_RUN: begin
          we_q <= we_d;
          if (i_valid) begin
            addr_q  <= i_dest;
            data_q  <= data_d;
            count_q <= count_q + 32'd1;
            if (i_halt) begin
              state_q  <= WB_HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        default: begin
          // Frozen until reset
          we_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_write_enable = we_q;
  assign o_wb_write_addr   = addr_q;
  assign o_wb_write_data   = data_q;
  assign o_halted          = halted_q;
  assign o_retired_count   = count_q;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage with directed
//               scenarios and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        valid, reg_write, mem_to_reg, link, halt;
  logic [5:0]  opcode;
  logic [1:0]  byte_offset;
  logic [31:0] alu_result, mem_data, pc;
  logic [4:0]  dest;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_halted;
  logic [31:0] exp_count;

  writeback_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .LINK_OFFSET    (8)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst_n),
    .i_valid           (valid),
    .i_reg_write       (reg_write),
    .i_mem_to_reg      (mem_to_reg),
    .i_link            (link),
    .i_halt            (halt),
    .i_opcode          (opcode),
    .i_byte_offset     (byte_offset),
    .i_alu_result      (alu_result),
    .i_mem_data        (mem_data),
    .i_pc              (pc),
    .i_dest            (dest),
    .o_wb_write_enable (wb_we),
    .o_wb_write_addr   (wb_addr),
    .o_wb_write_data   (wb_data),
    .o_halted          (halted),
    .o_retired_count   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural load value computed arithmetically from the opcode rules
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] off,
                                             input logic [31:0] word);
    longint unsigned b, h;
    b = (longint'(word) >> (8 * off)) & 64'hFF;
    h = (longint'(word) >> (16 * off[1])) & 64'hFFFF;
    case (op)
      6'b100000: return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
      6'b100100: return 32'(b);
      6'b100001: return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
      6'b100101: return 32'(h);
      default:   return word;
    endcase
  endfunction

  function automatic logic [31:0] model_value(input logic lk, input logic m2r,
                                              input logic [5:0] op, input logic [1:0] off,
                                              input logic [31:0] alu, input logic [31:0] mem,
                                              input logic [31:0] p);
    if (lk)  return 32'((longint'(p) + 8) % 64'h1_0000_0000);
    if (m2r) return model_load(op, off, mem);
    return alu;
  endfunction

  // Present one instruction, advance the model, and step to #1 after the edge
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic lk,
                       input logic h, input logic [5:0] op, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] p, input logic [4:0] d);
    valid = v; reg_write = rw; mem_to_reg = m2r; link = lk; halt = h;
    opcode = op; byte_offset = off; alu_result = alu; mem_data = mem; pc = p; dest = d;
    if (exp_halted) begin
      exp_we = 1'b0;
    end else begin
      exp_we = v && rw && (d != 0) && !h;
      if (v) begin
        exp_addr  = d;
        exp_data  = model_value(lk, m2r, op, off, alu, mem, p);
        exp_count = exp_count + 1;
        if (h) exp_halted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_we = 0; exp_addr = 0; exp_data = 0; exp_halted = 0; exp_count = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({wb_we, wb_addr, wb_data, halted, retired} !== 71'd0) begin
      bad++;
      $display("FAIL reset: got we=%b addr=%0d data=%h halted=%b count=%0d, want all 0",
               wb_we, wb_addr, wb_data, halted, retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_alu();
    drive(1, 1, 0, 0, 0, 6'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd5);
    total++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'h12345678 || retired !== 32'd1) begin
      bad++;
      $display("FAIL alu_write: got we=%b addr=%0d data=%h count=%0d, want 1/5/12345678/1",
               wb_we, wb_addr, wb_data, retired);
    end
  endtask

  task automatic test_loads();
    logic [5:0]  ops  [5] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] want [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, ops[i], offs[i], 32'hDEADBEEF, 32'h80FF7F01, 32'h0, 5'd7);
      total++;
      if (wb_data !== want[i] || wb_we !== 1'b1) begin
        bad++;
        $display("FAIL load_%0d op=%b: got data=%h we=%b, want %h we=1",
                 i, ops[i], wb_data, wb_we, want[i]);
      end
    end
  endtask

  task automatic test_link();
    drive(1, 1, 1, 1, 0, 6'b100011, 2'd0, 32'h11111111, 32'h22222222, 32'h00000040, 5'd31);
    total++;
    if (wb_data !== 32'h00000048 || wb_addr !== 5'd31 || wb_we !== 1'b1) begin
      bad++;
      $display("FAIL link: got data=%h addr=%0d we=%b, want 00000048/31/1",
               wb_data, wb_addr, wb_we);
    end
  endtask

  task automatic test_zero_and_bubble();
    logic [31:0] c0;
    c0 = exp_count;
    drive(1, 1, 0, 0, 0, 6'd0, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd0);
    total++;
    if (wb_we !== 1'b0 || retired !== c0 + 1 || wb_addr !== 5'd0 || wb_data !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL reg0_guard: got we=%b count=%0d addr=%0d data=%h, want 0/%0d/0/cafef00d",
               wb_we, retired, wb_addr, wb_data, c0 + 1);
    end
    drive(0, 1, 0, 0, 0, 6'd0, 2'd0, 32'h55555555, 32'h0, 32'h0, 5'd9);
    total++;
    if (wb_we !== 1'b0 || retired !== c0 + 1 || wb_addr !== 5'd0 || wb_data !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL bubble: got we=%b count=%0d addr=%0d data=%h, want 0/%0d/0/cafef00d",
               wb_we, retired, wb_addr, wb_data, c0 + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, 1'b0,
            ($urandom_range(0, 1) != 0) ? (6'b100000 | 6'($urandom_range(0, 5))) : 6'($urandom),
            2'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      total++;
      if (wb_we !== exp_we || wb_addr !== exp_addr || wb_data !== exp_data ||
          retired !== exp_count || halted !== exp_halted) begin
        bad++;
        $display("FAIL random_%0d: got we=%b addr=%0d data=%h count=%0d halted=%b, want %b/%0d/%h/%0d/%b",
                 i, wb_we, wb_addr, wb_data, retired, halted,
                 exp_we, exp_addr, exp_data, exp_count, exp_halted);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    c0 = exp_count;
    drive(1, 1, 0, 0, 1, 6'd0, 2'd0, 32'h33333333, 32'h0, 32'h0, 5'd3);
    total++;
    if (wb_we !== 1'b0 || halted !== 1'b1 || retired !== c0 + 1) begin
      bad++;
      $display("FAIL halt_capture: got we=%b halted=%b count=%0d, want 0/1/%0d",
               wb_we, halted, retired, c0 + 1);
    end
    drive(1, 1, 0, 0, 0, 6'd0, 2'd0, 32'h44444444, 32'h0, 32'h0, 5'd4);
    total++;
    if (wb_we !== 1'b0 || halted !== 1'b1 || retired !== c0 + 1 || wb_addr !== 5'd3) begin
      bad++;
      $display("FAIL halted_ignore: got we=%b halted=%b count=%0d addr=%0d, want 0/1/%0d/3",
               wb_we, halted, retired, wb_addr, c0 + 1);
    end
    // Asynchronous reset takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0 || retired !== 32'd0 || wb_we !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset: got halted=%b count=%0d we=%b, want 0/0/0", halted, retired, wb_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(1, 1, 0, 0, 0, 6'd0, 2'd0, 32'h66666666, 32'h0, 32'h0, 5'd6);
    total++;
    if (wb_we !== 1'b1 || wb_data !== 32'h66666666 || retired !== 32'd1) begin
      bad++;
      $display("FAIL post_reset_run: got we=%b data=%h count=%0d, want 1/66666666/1",
               wb_we, wb_data, retired);
    end
  endtask

  task automatic test_wrap();
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFFFFFF;
    drive(1, 0, 0, 0, 0, 6'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1);
    total++;
    if (retired !== 32'd0) begin
      bad++;
      $display("FAIL wrap: got count=%h, want 00000000", retired);
    end
  endtask

  initial begin
    valid = 0; reg_write = 0; mem_to_reg = 0; link = 0; halt = 0;
    opcode = 0; byte_offset = 0; alu_result = 0; mem_data = 0; pc = 0; dest = 0;
    rst_n = 1'b1;
    model_reset();
    #2;
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_zero_and_bubble();
    test_random();
    test_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_writeback_stage
`default_nettype wire
